// File: rtl/univ_shift_reg_amisha.sv
// Universal WIDTH-bit shift register: load, logical/arithmetic shifts, rotates and sync clear,
// with a saturating shift counter and a one-cycle completion pulse for SERDES use.
module univ_shift_reg_amisha #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk_amisha,
  input  logic                       reset_amisha,
  input  logic                       clr_amisha,
  input  logic                       en_amisha,
  input  logic [2:0]                 mode_amisha,
  input  logic                       sin_lsb_amisha,
  input  logic                       sin_msb_amisha,
  input  logic [WIDTH-1:0]           d_amisha,
  output logic [WIDTH-1:0]           q_amisha,
  output logic                       sout_msb_amisha,
  output logic                       sout_lsb_amisha,
  output logic [$clog2(WIDTH+1)-1:0] cnt_amisha,
  output logic                       done_amisha
);

  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ASR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_LOAD = 3'b110;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_next_s;
  logic             done_r;
  logic             done_next_s;
  logic             is_shift_s;

  // Next-state selection: clear beats hold-on-disable, which beats the mode decode.
  always_comb begin
    q_next_s    = q_r;
    cnt_next_s  = cnt_r;
    done_next_s = 1'b0;
    is_shift_s  = 1'b0;
    if (clr_amisha) begin
      q_next_s   = RESET_VAL;
      cnt_next_s = {CW{1'b0}};
    end else if (en_amisha) begin
      case (mode_amisha)
        MODE_SHL: begin
          q_next_s   = {q_r[WIDTH-2:0], sin_lsb_amisha};
          is_shift_s = 1'b1;
        end
        MODE_SHR: begin
          q_next_s   = {sin_msb_amisha, q_r[WIDTH-1:1]};
          is_shift_s = 1'b1;
        end
        MODE_ASR: begin
          q_next_s   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
          is_shift_s = 1'b1;
        end
        MODE_ROL: begin
          q_next_s   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
          is_shift_s = 1'b1;
        end
        MODE_ROR: begin
          q_next_s   = {q_r[0], q_r[WIDTH-1:1]};
          is_shift_s = 1'b1;
        end
        MODE_LOAD: begin
          q_next_s   = d_amisha;
          cnt_next_s = {CW{1'b0}};
        end
        default: begin
          q_next_s = q_r;
        end
      endcase
      // The pulse marks only the step into saturation, never cycles spent at WIDTH.
      if (is_shift_s && (cnt_r < CNT_MAX)) begin
        cnt_next_s  = cnt_r + CNT_ONE;
        done_next_s = (cnt_r == (CNT_MAX - CNT_ONE));
      end else begin
        done_next_s = 1'b0;
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      q_r    <= RESET_VAL;
      cnt_r  <= {CW{1'b0}};
      done_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      cnt_r  <= cnt_next_s;
      done_r <= done_next_s;
    end
  end

  assign q_amisha        = q_r;
  assign cnt_amisha      = cnt_r;
  assign done_amisha     = done_r;
  assign sout_msb_amisha = q_r[WIDTH-1];
  assign sout_lsb_amisha = q_r[0];

endmodule
